alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: operation accepted this cycle when valid & ready.
REQ-006 The block SHALL have ports req0_op and req1_op, input, 4 bits each: opcode {funct7[5], funct3}.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 bits each: operands; shift amount is b[4:0].
REQ-008 The block SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_id (output, 1: index of the originating requester), resp_data (output, 32) and resp_err (output, 1: illegal opcode).
REQ-009 The block SHALL have ALU-side outputs alu_srcA and alu_srcB (32 bits each), alu_sel_a and alu_sel_comp (1 bit each), alu_sel_s, alu_sel_l and alu_sel_exec_out (2 bits each), and ALU-side input alu_exec_out (32 bits).

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-011 The FSM SHALL move IDLE->EXEC on accept, EXEC->RESP unconditionally, RESP->IDLE on resp_valid & resp_ready, and otherwise hold its state.
REQ-012 reqN_ready SHALL be 1 only in IDLE, only when reqN_valid = 1, and only when N is the granted requester; it SHALL be 0 in every other case.
REQ-013 Grant rule:
- only one requester valid -> grant it.
- both valid, RR_EN=1 -> grant the requester that is not last_grant.
- both valid, RR_EN=0 -> grant requester 0.
REQ-014 last_grant SHALL update to the accepted index on accept only; its reset value SHALL be 1, so requester 0 wins the first tie.
REQ-015 On accept, op, a, b and the requester index SHALL be captured into registers; alu_src* and alu_sel* SHALL be driven from these registers and stay stable through EXEC.
REQ-016 Decode (op -> sel_a, sel_comp, sel_s, sel_l, exec_out):
- ADD 0000 -> 0,-,-,-,00; SUB 1000 -> 1,-,-,-,00.
- SLT 0010 -> 1,1,-,-,01; SLTU 0011 -> 1,0,-,-,01.
- XOR 0100 -> -,-,-,00,10; OR 0110 -> -,-,-,01,10; AND 0111 -> -,-,-,10,10.
- SLL 0001 -> -,-,00,-,11; SRL 0101 -> -,-,10,-,11; SRA 1101 -> -,-,11,-,11.
- Don't-care fields ('-') SHALL be driven 0.
REQ-017 Any other opcode SHALL be illegal: resp_err=1, resp_data=0, with the same latency as a legal operation.
REQ-018 alu_exec_out SHALL be registered at the end of EXEC; resp_valid SHALL rise exactly 2 cycles after the accept edge.
REQ-019 While resp_valid=1 and resp_ready=0, resp_data, resp_id and resp_err SHALL stay stable and no new request SHALL be accepted.
REQ-020 After the response handshake, the FSM SHALL be in IDLE on the next cycle and able to accept that cycle; maximum throughput is one operation per 3 cycles.
REQ-021 Requester valid SHALL NOT depend combinationally on ready; a valid deasserted before accept SHALL NOT be granted.

Reset
REQ-022 When rst=1 at a clock edge, the FSM SHALL go to IDLE from any state, and any in-flight operation SHALL be dropped with no response.
REQ-023 Reset values: resp_valid, resp_id, resp_err and resp_data = 0; alu_srcA, alu_srcB and all alu_sel* = 0; last_grant = 1; req*_ready = 0 while rst=1.

Verification
REQ-024 Single op: req0 ADD a=5 b=7 -> resp_valid 2 cycles after accept, resp_data=12, resp_id=0, resp_err=0.
REQ-025 Tie: after reset, both valid (req0 SUB 3,5; req1 SRA 0x80000000,4) -> req0 served first with resp_data 0xFFFFFFFE, then req1 with 0xF8000000; with both held valid, grants alternate 0,1,0,1.
REQ-026 Compare: SLT a=0xFFFFFFFF b=1 -> resp_data=1; SLTU with the same operands -> resp_data=0.
REQ-027 Backpressure/illegal: op=1010 with resp_ready held 0 for 3 cycles -> resp_err=1 and resp_data=0 held stable, both reqN_ready=0 throughout, next accept only after the handshake.
REQ-028 Mid-op reset: rst asserted during EXEC -> next cycle IDLE, resp_valid=0, no response for the dropped op, and the next tie is granted to req0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels, the response channel
// and the ALU-side control/operand/result signals of alu_arbiter.
//   slave  : view used by alu_arbiter (requests/resp_ready/alu_exec_out in)
//   master : view used by the requesters, response sink and external ALU
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op,    req1_op;
  logic [31:0] req0_a,     req0_b;
  logic [31:0] req1_a,     req1_b;
  logic        resp_valid, resp_ready;
  logic        resp_id,    resp_err;
  logic [31:0] resp_data;
  logic [31:0] alu_srcA,   alu_srcB;
  logic        alu_sel_a,  alu_sel_comp;
  logic [1:0]  alu_sel_s,  alu_sel_l, alu_sel_exec_out;
  logic [31:0] alu_exec_out;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, resp_ready, alu_exec_out,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_err, resp_data,
           alu_srcA, alu_srcB, alu_sel_a, alu_sel_comp,
           alu_sel_s, alu_sel_l, alu_sel_exec_out
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, resp_ready, alu_exec_out,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_err, resp_data,
           alu_srcA, alu_srcB, alu_sel_a, alu_sel_comp,
           alu_sel_s, alu_sel_l, alu_sel_exec_out
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one external ALU.
// One operation at a time: IDLE (accept) -> EXEC (ALU evaluates the captured
// operands) -> RESP (hold result until resp_ready).
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_arbiter_if.slave -- requests, response, ALU side
// RR_EN = 1 round-robin on ties, 0 fixed priority to requester 0.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic        last_q;               // index of the last accepted requester
  logic        id_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] data_q;
  logic        rid_q, err_q;

  logic        grant, accept, hs;
  logic        rdy0, rdy1;
  logic        sel_a, sel_comp, illegal;
  logic [1:0]  sel_s, sel_l, sel_x;

  // Tie goes to the requester that did not win last time (RR) or to 0.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid)
      grant = RR_EN ? ~last_q : 1'b0;
    else
      grant = bus.req1_valid;
  end

  assign hs = (state_q == RESP) && bus.resp_ready;

  always_comb begin
    state_d = state_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state_q)
      IDLE: begin
        // ready is gated by rst so nothing looks accepted during reset
        rdy0 = !rst && bus.req0_valid && !grant;
        rdy1 = !rst && bus.req1_valid &&  grant;
        if (rdy0 || rdy1) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = rdy0 | rdy1;

  // Decode of the captured opcode; unused fields stay 0.
  always_comb begin
    sel_a    = 1'b0;
    sel_comp = 1'b0;
    sel_s    = 2'b00;
    sel_l    = 2'b00;
    sel_x    = 2'b00;
    illegal  = 1'b0;
    case (op_q)
      4'b0000: sel_x = 2'b00;                                        // ADD
      4'b1000: sel_a = 1'b1;                                         // SUB
      4'b0010: begin sel_a = 1'b1; sel_comp = 1'b1; sel_x = 2'b01; end // SLT
      4'b0011: begin sel_a = 1'b1; sel_x = 2'b01; end                // SLTU
      4'b0100: sel_x = 2'b10;                                        // XOR
      4'b0110: begin sel_l = 2'b01; sel_x = 2'b10; end               // OR
      4'b0111: begin sel_l = 2'b10; sel_x = 2'b10; end               // AND
      4'b0001: sel_x = 2'b11;                                        // SLL
      4'b0101: begin sel_s = 2'b10; sel_x = 2'b11; end               // SRL
      4'b1101: begin sel_s = 2'b11; sel_x = 2'b11; end               // SRA
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      data_q  <= 32'd0;
      rid_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= grant;
        id_q   <= grant;
        op_q   <= grant ? bus.req1_op : bus.req0_op;
        a_q    <= grant ? bus.req1_a  : bus.req0_a;
        b_q    <= grant ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == EXEC) begin
        data_q <= illegal ? 32'd0 : bus.alu_exec_out;
        rid_q  <= id_q;
        err_q  <= illegal;
      end
    end
  end

  assign bus.req0_ready       = rdy0;
  assign bus.req1_ready       = rdy1;
  assign bus.resp_valid       = (state_q == RESP);
  assign bus.resp_id          = rid_q;
  assign bus.resp_err         = err_q;
  assign bus.resp_data        = data_q;
  assign bus.alu_srcA         = a_q;
  assign bus.alu_srcB         = b_q;
  assign bus.alu_sel_a        = sel_a;
  assign bus.alu_sel_comp     = sel_comp;
  assign bus.alu_sel_s        = sel_s;
  assign bus.alu_sel_l        = sel_l;
  assign bus.alu_sel_exec_out = sel_x;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();
  alu_arbiter #(.RR_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural ALU driven only by the select lines.
  always_comb begin
    logic [4:0] sa;
    sa = bus.alu_srcB[4:0];
    bus.alu_exec_out = 32'd0;
    case (bus.alu_sel_exec_out)
      2'b00: bus.alu_exec_out = bus.alu_sel_a ? bus.alu_srcA - bus.alu_srcB
                                              : bus.alu_srcA + bus.alu_srcB;
      2'b01: bus.alu_exec_out = bus.alu_sel_comp
               ? {31'd0, $signed(bus.alu_srcA) < $signed(bus.alu_srcB)}
               : {31'd0, bus.alu_srcA < bus.alu_srcB};
      2'b10: case (bus.alu_sel_l)
               2'b00:   bus.alu_exec_out = bus.alu_srcA ^ bus.alu_srcB;
               2'b01:   bus.alu_exec_out = bus.alu_srcA | bus.alu_srcB;
               2'b10:   bus.alu_exec_out = bus.alu_srcA & bus.alu_srcB;
               default: bus.alu_exec_out = 32'd0;
             endcase
      default: case (bus.alu_sel_s)
               2'b00:   bus.alu_exec_out = bus.alu_srcA << sa;
               2'b10:   bus.alu_exec_out = bus.alu_srcA >> sa;
               2'b11:   bus.alu_exec_out = $unsigned($signed(bus.alu_srcA) >>> sa);
               default: bus.alu_exec_out = 32'd0;
             endcase
    endcase
  end

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cnt = 0, resp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] d, input logic e);
    exp_t x;
    x.id = id; x.data = d; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_acc(input int n);
    for (int k = 0; k < 200 && acc_cnt < n; k++) @(posedge clk);
    if (acc_cnt < n) chk("accept_timeout", acc_cnt, n);
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 200 && resp_cnt < n; k++) @(posedge clk);
    if (resp_cnt < n) chk("resp_timeout", resp_cnt, n);
  endtask

  task automatic op1(input logic id, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] d, input logic e);
    int rb;
    rb = resp_cnt;
    #1;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    push(id, d, e);
    wait_acc(acc_cnt + 1);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_resp(rb + 1);
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  logic        rv_prev = 1'b0, rr_prev = 1'b0, pid, perr;
  logic [31:0] pdata;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_cyc.delete();
      rv_prev = 1'b0;
    end else begin
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
      if (bus.resp_valid) begin
        chk("ready_while_resp", {bus.req0_ready, bus.req1_ready}, 32'd0);
        if (!rv_prev) begin
          if (acc_cyc.size() == 0) chk("resp_without_accept", 32'd1, 32'd0);
          else chk("resp_latency", cyc - acc_cyc[0], 32'd2);
        end else if (!rr_prev) begin
          chk("stall_data", bus.resp_data, pdata);
          chk("stall_id",   bus.resp_id,   pid);
          chk("stall_err",  bus.resp_err,  perr);
        end
        if (bus.resp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
          else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("resp_id",   bus.resp_id,   x.id);
            chk("resp_data", bus.resp_data, x.data);
            chk("resp_err",  bus.resp_err,  x.err);
          end
          if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
          resp_cnt++;
        end
      end
      rv_prev = bus.resp_valid;
      rr_prev = bus.resp_ready;
      pdata   = bus.resp_data;
      pid     = bus.resp_id;
      perr    = bus.resp_err;
    end
  end

  initial begin
    int rb, ab;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_op = 4'd0; bus.req1_op = 4'd0;
    bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 32'd0);
    chk("rst_resp_valid", bus.resp_valid, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_id_err", {bus.resp_id, bus.resp_err}, 32'd0);
    chk("rst_srcA", bus.alu_srcA, 32'd0);
    chk("rst_srcB", bus.alu_srcB, 32'd0);
    chk("rst_sels", {bus.alu_sel_a, bus.alu_sel_comp, bus.alu_sel_s,
                     bus.alu_sel_l, bus.alu_sel_exec_out}, 32'd0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);

    // Tie held for four grants: 0,1,0,1
    #1;
    ab = acc_cnt; rb = resp_cnt;
    bus.req0_op = 4'b1000; bus.req0_a = 32'd3;          bus.req0_b = 32'd5;
    bus.req1_op = 4'b1101; bus.req1_a = 32'h8000_0000;  bus.req1_b = 32'd4;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(1'b0, 32'hFFFF_FFFE, 1'b0);
      push(1'b1, 32'hF800_0000, 1'b0);
    end
    wait_acc(ab + 4);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_resp(rb + 4);

    // Single operations
    op1(1'b0, 4'b0000, 32'd5,         32'd7,         32'd12,         1'b0); // ADD
    op1(1'b1, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0,  1'b0); // XOR
    op1(1'b0, 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0,  1'b0); // OR
    op1(1'b1, 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000,  1'b0); // AND
    op1(1'b0, 4'b0001, 32'd1,         32'h24,        32'h10,         1'b0); // SLL
    op1(1'b1, 4'b0101, 32'h8000_0000, 32'd4,         32'h0800_0000,  1'b0); // SRL
    op1(1'b0, 4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b0); // SLTU

    // Illegal op under backpressure, req0 waiting behind it
    #1;
    rb = resp_cnt;
    bus.resp_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 4'b1010; bus.req1_a = 32'd1; bus.req1_b = 32'd2;
    push(1'b1, 32'd0, 1'b1);
    wait_acc(acc_cnt + 1);
    #1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 4'b0010; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1;
    push(1'b0, 32'd1, 1'b0);                                              // SLT
    repeat (5) @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    wait_acc(acc_cnt + 1);
    #1;
    bus.req0_valid = 1'b0;
    wait_resp(rb + 2);

    // Reset during EXEC: op dropped, last_grant back to 1
    #1;
    bus.req0_valid = 1'b1; bus.req0_op = 4'b0000; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    wait_acc(acc_cnt + 1);
    #1;
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", bus.resp_valid, 32'd0);
    repeat (4) @(posedge clk);
    chk("midrst_no_resp", exp_q.size(), 32'd0);
    #1;
    ab = acc_cnt; rb = resp_cnt;
    bus.req0_op = 4'b1000; bus.req0_a = 32'd3;         bus.req0_b = 32'd5;
    bus.req1_op = 4'b1101; bus.req1_a = 32'h8000_0000; bus.req1_b = 32'd4;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    push(1'b0, 32'hFFFF_FFFE, 1'b0);
    push(1'b1, 32'hF800_0000, 1'b0);
    wait_acc(ab + 2);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_resp(rb + 2);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
